// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - parametrised vending controller with refund, stock and restock
module vending_machine_param #(
    parameter int PRICE     = 3,
    parameter int VAL_C1    = 1,
    parameter int VAL_C2    = 2,
    parameter int VAL_C3    = 10,
    parameter int STOCK_MAX = 8,
    parameter int CHG_W     = 4,
    parameter int STK_W     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       coin,
    input  logic             cancel,
    input  logic             restock,
    output logic             sell,
    output logic [CHG_W-1:0] change,
    output logic             change_vld,
    output logic [CHG_W-1:0] credit,
    output logic [STK_W-1:0] stock,
    output logic             sold_out
);
    typedef enum logic [1:0] {IDLE, COLLECT, EMPTY} state_t;

    localparam logic [CHG_W:0]   PRICE_W = (CHG_W+1)'(PRICE);
    localparam logic [CHG_W:0]   V1      = (CHG_W+1)'(VAL_C1);
    localparam logic [CHG_W:0]   V2      = (CHG_W+1)'(VAL_C2);
    localparam logic [CHG_W:0]   V3      = (CHG_W+1)'(VAL_C3);
    localparam logic [STK_W-1:0] FULL    = STK_W'(STOCK_MAX);
    localparam logic [STK_W-1:0] ONE     = STK_W'(1);

    state_t           state, state_n;
    logic [CHG_W:0]   v, sum;
    logic [CHG_W-1:0] credit_n, change_n;
    logic [STK_W-1:0] stock_n;
    logic             sell_n, vld_n;

    always_comb begin
        case (coin)
            2'b01:   v = V1;
            2'b10:   v = V2;
            2'b11:   v = V3;
            default: v = '0;
        endcase
    end

    // One extra bit so a large coin on top of credit cannot wrap before the price compare
    assign sum = {1'b0, credit} + v;

    always_comb begin
        state_n  = state;
        credit_n = credit;
        stock_n  = stock;
        change_n = '0;
        sell_n   = 1'b0;
        vld_n    = 1'b0;
        case (state)
            EMPTY: begin
                if (v != '0) begin
                    vld_n    = 1'b1;
                    change_n = CHG_W'(v);
                end
                if (restock) begin
                    stock_n = FULL;
                    state_n = IDLE;
                end
            end
            default: begin
                if (cancel) begin
                    vld_n    = 1'b1;
                    change_n = CHG_W'(sum);
                    credit_n = '0;
                    state_n  = IDLE;
                end else if (sum >= PRICE_W) begin
                    sell_n   = 1'b1;
                    vld_n    = 1'b1;
                    change_n = CHG_W'(sum - PRICE_W);
                    credit_n = '0;
                    stock_n  = stock - ONE;
                    state_n  = (stock == ONE) ? EMPTY : IDLE;
                end else if (v != '0) begin
                    credit_n = CHG_W'(sum);
                    state_n  = COLLECT;
                end
                // Restock wins over a same-cycle decrement, so the machine never empties here
                if (restock) begin
                    stock_n = FULL;
                    if (state_n == EMPTY) state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            credit     <= '0;
            stock      <= FULL;
            sold_out   <= 1'b0;
            sell       <= 1'b0;
            change     <= '0;
            change_vld <= 1'b0;
        end else begin
            state      <= state_n;
            credit     <= credit_n;
            stock      <= stock_n;
            sold_out   <= (stock_n == '0);
            sell       <= sell_n;
            change     <= change_n;
            change_vld <= vld_n;
        end
    end
endmodule

// File: tb/tb_vending_machine_param.sv
// tb/tb_vending_machine_param.sv - directed and random checks of vending_machine_param against a value model
module tb_vending_machine_param;
    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] coin;
    logic       cancel, restock;
    logic       sell, change_vld, sold_out;
    logic [3:0] change, credit, stock;

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    // Model: money and item counts as plain integers
    int m_credit, m_stock, e_change;
    bit e_sell, e_vld;

    vending_machine_param dut (
        .clk(clk), .rstn(rstn), .coin(coin), .cancel(cancel), .restock(restock),
        .sell(sell), .change(change), .change_vld(change_vld), .credit(credit),
        .stock(stock), .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
        end
    endtask

    function automatic int coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 10;
            default: return 0;
        endcase
    endfunction

    task automatic model(input logic [1:0] c, input bit can, input bit rs, input bit rst);
        int v, sum;
        v = coin_value(c);
        e_sell = 0; e_vld = 0; e_change = 0;
        if (rst) begin
            m_credit = 0;
            m_stock  = 8;
        end else if (m_stock == 0) begin
            e_vld    = (v > 0);
            e_change = v;
            if (rs) m_stock = 8;
        end else begin
            sum = m_credit + v;
            if (can) begin
                e_vld = 1; e_change = sum; m_credit = 0;
            end else if (sum >= 3) begin
                e_sell = 1; e_vld = 1; e_change = sum - 3; m_credit = 0;
                m_stock = m_stock - 1;
            end else begin
                m_credit = sum;
            end
            if (rs) m_stock = 8;
        end
    endtask

    task automatic step(input logic [1:0] c, input bit can, input bit rs, input bit rst);
        coin = c; cancel = can; restock = rs; rstn = !rst;
        @(posedge clk);
        model(c, can, rs, rst);
        #1;
        step_no++;
        chk("sell",       32'(sell),       32'(e_sell));
        chk("change_vld", 32'(change_vld), 32'(e_vld));
        chk("change",     32'(change),     32'(e_change));
        chk("credit",     32'(credit),     32'(m_credit));
        chk("stock",      32'(stock),      32'(m_stock));
        chk("sold_out",   32'(sold_out),   32'(m_stock == 0));
        coin = 2'b00; cancel = 1'b0; restock = 1'b0; rstn = 1'b1;
    endtask

    initial begin
        coin = 2'b00; cancel = 1'b0; restock = 1'b0; rstn = 1'b0;
        m_credit = 0; m_stock = 8;
        step(2'b00, 0, 0, 1);
        step(2'b00, 0, 0, 1);
        // T1
        step(2'b01, 0, 0, 0);
        step(2'b01, 0, 0, 0);
        step(2'b01, 0, 0, 0);
        // T2
        step(2'b10, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        // T3
        step(2'b11, 0, 0, 0);
        // T4
        step(2'b01, 0, 0, 0);
        step(2'b10, 1, 0, 0);
        // T5: drain remaining stock, reject a coin, restock, vend again
        while (m_stock > 0) step(2'b11, 0, 0, 0);
        step(2'b00, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        step(2'b00, 1, 0, 0);
        step(2'b01, 0, 1, 0);
        step(2'b01, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        // Restock coinciding with the last vend keeps the machine full
        while (m_stock > 1) step(2'b11, 0, 0, 0);
        step(2'b11, 0, 1, 0);
        // T6
        step(2'b10, 0, 0, 0);
        step(2'b00, 0, 0, 1);
        step(2'b01, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 299) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
